// File: rtl/decode_pkg.sv
// Shared constants for the instruction-decode stage: opcodes, ALU codes,
// instruction field positions and the decoded control bundle.
package decode_pkg;

  localparam int OPC_LO  = 26;
  localparam int OPC_W   = 6;
  localparam int RD_LO   = 21;
  localparam int RS1_LO  = 16;
  localparam int RS2_LO  = 11;
  localparam int IMM_LO  = 0;
  localparam int IMM_W   = 16;
  localparam int FUNC_LO = 0;
  localparam int FUNC_W  = 4;

  localparam logic [OPC_W-1:0] OP_NOP   = 6'd0;
  localparam logic [OPC_W-1:0] OP_ALU   = 6'd1;
  localparam logic [OPC_W-1:0] OP_ADDI  = 6'd2;
  localparam logic [OPC_W-1:0] OP_LOAD  = 6'd3;
  localparam logic [OPC_W-1:0] OP_STORE = 6'd4;
  localparam logic [OPC_W-1:0] OP_BEQ   = 6'd5;

  localparam logic [FUNC_W-1:0] ALU_ADD = 4'd0;
  localparam logic [FUNC_W-1:0] ALU_SUB = 4'd1;

  typedef struct packed {
    logic [FUNC_W-1:0] alu_op;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              branch;
    logic              use_imm;
    logic              illegal;
    logic              use_rs1;
    logic              use_rs2;
  } ctrl_t;

endpackage

// File: rtl/decode_instr_decoder.sv
// Pure combinational opcode decoder: control flags plus which source
// registers the instruction actually reads (used by hazard detection).
module instr_decoder
  import decode_pkg::*;
(
  input  logic [OPC_W-1:0]  i_opcode,
  input  logic [FUNC_W-1:0] i_func,
  output ctrl_t             o_ctrl
);

  // opcode to control-flag mapping; unknown opcodes raise illegal only
  always_comb begin
    o_ctrl = '0;
    case (i_opcode)
      OP_NOP: begin
        o_ctrl.alu_op = ALU_ADD;
      end
      OP_ALU: begin
        o_ctrl.alu_op    = i_func;
        o_ctrl.reg_write = 1'b1;
        o_ctrl.use_rs1   = 1'b1;
        o_ctrl.use_rs2   = 1'b1;
      end
      OP_ADDI: begin
        o_ctrl.alu_op    = ALU_ADD;
        o_ctrl.reg_write = 1'b1;
        o_ctrl.use_imm   = 1'b1;
        o_ctrl.use_rs1   = 1'b1;
      end
      OP_LOAD: begin
        o_ctrl.alu_op    = ALU_ADD;
        o_ctrl.reg_write = 1'b1;
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.use_imm   = 1'b1;
        o_ctrl.use_rs1   = 1'b1;
      end
      OP_STORE: begin
        o_ctrl.alu_op    = ALU_ADD;
        o_ctrl.mem_write = 1'b1;
        o_ctrl.use_rs1   = 1'b1;
        o_ctrl.use_rs2   = 1'b1;
      end
      OP_BEQ: begin
        o_ctrl.alu_op  = ALU_SUB;
        o_ctrl.branch  = 1'b1;
        o_ctrl.use_rs1 = 1'b1;
        o_ctrl.use_rs2 = 1'b1;
      end
      default: begin
        o_ctrl.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Instruction-decode stage: register-file read indices, write-back bypass,
// load-use stall detection, flush handling and the ID/EX pipeline register.
module decode_stage
  import decode_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 5,
  parameter int PC_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_valid,
  input  logic [31:0]       if_instr,
  input  logic [PC_W-1:0]   if_pc,
  input  logic              flush,
  output logic              stall,
  output logic [IDX_W-1:0]  read_index_1,
  output logic [IDX_W-1:0]  read_index_2,
  input  logic [DATA_W-1:0] read_data_1,
  input  logic [DATA_W-1:0] read_data_2,
  input  logic              wb_write_enable,
  input  logic [IDX_W-1:0]  wb_write_index,
  input  logic [DATA_W-1:0] wb_write_data,
  output logic              ex_valid,
  output logic [PC_W-1:0]   ex_pc,
  output logic [3:0]        ex_alu_op,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_branch,
  output logic              ex_use_imm,
  output logic              ex_illegal,
  output logic [IDX_W-1:0]  ex_rd,
  output logic [IDX_W-1:0]  ex_rs1,
  output logic [IDX_W-1:0]  ex_rs2,
  output logic [DATA_W-1:0] ex_op_a,
  output logic [DATA_W-1:0] ex_op_b,
  output logic [DATA_W-1:0] ex_imm
);

  logic [OPC_W-1:0]  w_opcode;
  logic [FUNC_W-1:0] w_func;
  logic [IDX_W-1:0]  w_rd;
  logic [IDX_W-1:0]  w_rs1;
  logic [IDX_W-1:0]  w_rs2;
  logic [DATA_W-1:0] w_imm;
  ctrl_t             w_ctrl;
  logic              w_hazard;
  logic              w_stall;
  logic [DATA_W-1:0] w_op_a;
  logic [DATA_W-1:0] w_op_b;

  logic              r_ex_valid;
  logic [PC_W-1:0]   r_ex_pc;
  logic [3:0]        r_ex_alu_op;
  logic              r_ex_reg_write;
  logic              r_ex_mem_read;
  logic              r_ex_mem_write;
  logic              r_ex_branch;
  logic              r_ex_use_imm;
  logic              r_ex_illegal;
  logic [IDX_W-1:0]  r_ex_rd;
  logic [IDX_W-1:0]  r_ex_rs1;
  logic [IDX_W-1:0]  r_ex_rs2;
  logic [DATA_W-1:0] r_ex_op_a;
  logic [DATA_W-1:0] r_ex_op_b;
  logic [DATA_W-1:0] r_ex_imm;

  assign w_opcode = if_instr[OPC_LO +: OPC_W];
  assign w_func   = if_instr[FUNC_LO +: FUNC_W];
  assign w_rd     = if_instr[RD_LO +: IDX_W];
  assign w_rs1    = if_instr[RS1_LO +: IDX_W];
  assign w_rs2    = if_instr[RS2_LO +: IDX_W];
  assign w_imm    = DATA_W'(if_instr[IMM_LO +: IMM_W]);

  assign read_index_1 = w_rs1;
  assign read_index_2 = w_rs2;

  instr_decoder u_instr_decoder (
    .i_opcode (w_opcode),
    .i_func   (w_func),
    .o_ctrl   (w_ctrl)
  );

  // load in EX whose destination is a source this instruction really reads
  always_comb begin
    w_hazard = if_valid & r_ex_valid & r_ex_mem_read &
               ((w_ctrl.use_rs1 & (r_ex_rd == w_rs1)) |
                (w_ctrl.use_rs2 & (r_ex_rd == w_rs2)));
    w_stall  = w_hazard & ~flush;
  end

  assign stall = w_stall;

  // the register file writes at this edge, so forward the write-back value
  always_comb begin
    if (wb_write_enable && (wb_write_index == w_rs1)) begin
      w_op_a = wb_write_data;
    end else begin
      w_op_a = read_data_1;
    end
    if (wb_write_enable && (wb_write_index == w_rs2)) begin
      w_op_b = wb_write_data;
    end else begin
      w_op_b = read_data_2;
    end
  end

  // ID/EX register: reset > flush > stall bubble > decoded bundle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex_valid     <= 1'b0;
      r_ex_pc        <= '0;
      r_ex_alu_op    <= 4'd0;
      r_ex_reg_write <= 1'b0;
      r_ex_mem_read  <= 1'b0;
      r_ex_mem_write <= 1'b0;
      r_ex_branch    <= 1'b0;
      r_ex_use_imm   <= 1'b0;
      r_ex_illegal   <= 1'b0;
      r_ex_rd        <= '0;
      r_ex_rs1       <= '0;
      r_ex_rs2       <= '0;
      r_ex_op_a      <= '0;
      r_ex_op_b      <= '0;
      r_ex_imm       <= '0;
    end else if (flush || w_stall) begin
      r_ex_valid     <= 1'b0;
      r_ex_reg_write <= 1'b0;
      r_ex_mem_read  <= 1'b0;
      r_ex_mem_write <= 1'b0;
      r_ex_branch    <= 1'b0;
      r_ex_use_imm   <= 1'b0;
      r_ex_illegal   <= 1'b0;
    end else begin
      r_ex_valid     <= if_valid;
      r_ex_reg_write <= if_valid & w_ctrl.reg_write;
      r_ex_mem_read  <= if_valid & w_ctrl.mem_read;
      r_ex_mem_write <= if_valid & w_ctrl.mem_write;
      r_ex_branch    <= if_valid & w_ctrl.branch;
      r_ex_use_imm   <= if_valid & w_ctrl.use_imm;
      r_ex_illegal   <= if_valid & w_ctrl.illegal;
      r_ex_pc        <= if_pc;
      r_ex_alu_op    <= w_ctrl.alu_op;
      r_ex_rd        <= w_rd;
      r_ex_rs1       <= w_rs1;
      r_ex_rs2       <= w_rs2;
      r_ex_op_a      <= w_op_a;
      r_ex_op_b      <= w_op_b;
      r_ex_imm       <= w_imm;
    end
  end

  assign ex_valid     = r_ex_valid;
  assign ex_pc        = r_ex_pc;
  assign ex_alu_op    = r_ex_alu_op;
  assign ex_reg_write = r_ex_reg_write;
  assign ex_mem_read  = r_ex_mem_read;
  assign ex_mem_write = r_ex_mem_write;
  assign ex_branch    = r_ex_branch;
  assign ex_use_imm   = r_ex_use_imm;
  assign ex_illegal   = r_ex_illegal;
  assign ex_rd        = r_ex_rd;
  assign ex_rs1       = r_ex_rs1;
  assign ex_rs2       = r_ex_rs2;
  assign ex_op_a      = r_ex_op_a;
  assign ex_op_b      = r_ex_op_b;
  assign ex_imm       = r_ex_imm;

endmodule
